if_id_skid: RTL
===============

# if_id_skid

Parametrised IF→ID pipeline stage register with a valid/ready handshake, a one-entry skid buffer and a synchronous flush.
- Sits between fetch and decode, like the plain IF/ID register, but adds:
  - back-pressure from decode without losing fetched words;
  - full throughput;
  - branch-flush that inserts NOP bubbles.
- Payload is the PC and instruction word, both of configurable width.

## Interface
- PC_W, default 8, PC width in bits
- INSTR_W, default 16, instruction width in bits
- NOP, default all-zero INSTR_W, instruction presented when the stage is empty or flushed
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents a word this cycle
- in_ready  out  1  stage accepts a word this cycle
- in_pc  in  PC_W  PC of presented word
- in_instr  in  INSTR_W  presented instruction
- out_valid  out  1  output register holds a live word
- out_ready  in  1  decode consumes the word this cycle
- out_pc  out  PC_W  PC of output word
- out_instr  out  INSTR_W  output instruction
- flush  in  1  discard all held words and any word pushed this cycle
- occupancy  out  2  number of held words, 0..2

## Operation
- Handshake events:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- Storage: main register (drives the outputs) and skid register.
- State machine with three states: EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
- Outputs:
  - in_ready = (state != TWO), decoded from registered state only; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - occupancy is the encoded state.
- Transitions when flush=0:
  - EMPTY, push → ONE; main ← in.
  - ONE, push & !pop → TWO; skid ← in.
  - ONE, pop & !push → EMPTY; main ← {0, NOP}.
  - ONE, push & pop → ONE; main ← in.
  - TWO, pop → ONE; main ← skid; skid ← {0, NOP}. No push is possible in TWO.
  - Any other case: hold.
- Flush:
  - flush=1 in any state → EMPTY.
  - main and skid ← {0, NOP}.
  - A simultaneous push is discarded; a simultaneous pop still counts as consumed by decode.
- Empty-stage outputs: out_pc=0 and out_instr=NOP. Decode never sees stale data.
- Ordering: words leave in exactly arrival order. No duplication, no loss except by flush.
- Data paths are pure register copies; no arithmetic on PC.

## Timing
- Reset values (asynchronous, immediate on rst rise):
  - state=EMPTY, in_ready=1, out_valid=0;
  - out_pc=0, out_instr=NOP, occupancy=0;
  - skid cleared.
- Reset asserted mid-transfer drops all words; the first edge after release behaves as EMPTY.
- Latency: a word pushed at edge N appears on out_* after edge N (one cycle), when the stage was EMPTY or popping in ONE.
- Throughput: one word per cycle sustained while out_ready=1.
- Skid behaviour:
  - A single cycle of out_ready=0 is absorbed.
  - in_ready drops in the cycle after the skid fills.
  - in_ready recovers in the cycle after the first pop from TWO.
- Flush takes effect at the next edge. out_valid=0 is seen the cycle after flush is sampled.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding (EMPTY, ONE, TWO as a 2-bit enum, values 0, 1, 2 so occupancy = state);
  - the default NOP constant.
- Natural sub-module: pipe_slot, a clearable PC+instr register with load and clear enables.
  - Instantiated twice: main and skid.
- Control FSM lives in the top module.

## Test plan
- Reset then stream: assert and release rst; push PC 0x10..0x14 with instr 0xA000+PC, out_ready=1 → each word appears one cycle later; occupancy ≤1; in_ready stays 1.
- Single stall: stream as above, out_ready=0 for one cycle at PC 0x12 → occupancy reaches 2, in_ready=0 for exactly one cycle; output sequence 0x10..0x14 is unchanged with no gaps beyond the stall.
- Long stall: out_ready=0 for 5 cycles → occupancy=2 and in_ready=0 held; out_pc stays constant; on release, skid word follows main word in order.
- Flush while full: occupancy=2 plus in_valid=1, assert flush → next cycle out_valid=0, out_instr=NOP, out_pc=0, occupancy=0, in_ready=1; the pushed word never appears.
- Async reset mid-stream: rst pulses between edges with occupancy=2 → outputs zero/NOP immediately; next accepted word PC 0x40 appears alone.
- Parameters PC_W=32, INSTR_W=32, NOP=0x00000013: rerun scenarios 1 and 4 → NOP value appears on flush/empty; full-width values pass intact.

Source files
------------

// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF->ID skid stage: occupancy state encoding
// and the default NOP instruction pattern.
package pipe_pkg;

  // State value equals the number of held words, so occupancy is the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  // Default NOP pattern (all-zero); the top truncates it to INSTR_W bits.
  localparam logic [63:0] NOP_DEFAULT = 64'h0;

endpackage : pipe_pkg

// File: rtl/if_id_skid_if.sv
// Valid/ready handshake bus carrying a PC and an instruction word.
// master drives valid/pc/instr and observes ready; slave is the reverse.
interface if_id_skid_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) ();

  logic               valid;
  logic               ready;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;

  modport master (output valid, output pc, output instr, input ready);
  modport slave  (input valid, input pc, input instr, output ready);

endinterface : if_id_skid_if

// File: rtl/if_id_skid_slot.sv
// One storage slot of the skid stage: a PC + instruction register with a
// load enable and a clear enable. Clear wins over load and returns the slot
// to the empty pattern {0, NOP}.
module pipe_slot #(
  parameter int                 PC_W    = 8,
  parameter int                 INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP     = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;

  // Slot register: async reset / clear to {0, NOP}, otherwise load or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= {PC_W{1'b0}};
      r_instr <= NOP;
    end else if (i_clear) begin
      r_pc    <= {PC_W{1'b0}};
      r_instr <= NOP;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else begin
      r_pc    <= r_pc;
      r_instr <= r_instr;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule : pipe_slot

// File: rtl/if_id_skid.sv
// IF->ID pipeline stage with valid/ready handshake, one-entry skid buffer and
// synchronous flush. The main slot drives decode; the skid slot catches the
// word accepted in the cycle decode stalls, so in_ready depends only on
// registered state and never on out_ready.
module if_id_skid
  import pipe_pkg::*;
#(
  parameter int                 PC_W    = 8,
  parameter int                 INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  if_id_skid_if.slave  in_bus,
  if_id_skid_if.master out_bus,
  input  logic         flush,
  output logic [1:0]   occupancy
);

  occ_state_e r_state;
  occ_state_e w_state_nxt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  logic w_main_load;
  logic w_main_clear;
  logic w_main_from_skid;
  logic w_skid_load;
  logic w_skid_clear;

  logic [PC_W-1:0]    w_main_pc_d;
  logic [INSTR_W-1:0] w_main_instr_d;
  logic [PC_W-1:0]    w_main_pc;
  logic [INSTR_W-1:0] w_main_instr;
  logic [PC_W-1:0]    w_skid_pc;
  logic [INSTR_W-1:0] w_skid_instr;

  // Handshake flags decoded from registered state only.
  assign w_in_ready  = (r_state != ST_TWO);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = in_bus.valid & w_in_ready;
  assign w_pop       = w_out_valid & out_bus.ready;

  // State register: occupancy of the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and slot-control decode; flush overrides every transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt = ST_ONE;
            w_main_load = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt = ST_TWO;
            w_skid_load = 1'b1;
          end else if (w_pop && !w_push) begin
            w_state_nxt  = ST_EMPTY;
            w_main_clear = 1'b1;
          end else if (w_push && w_pop) begin
            w_state_nxt = ST_ONE;
            w_main_load = 1'b1;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt      = ST_ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end else begin
            w_state_nxt = ST_TWO;
          end
        end
        default: begin
          w_state_nxt  = ST_EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Main slot source: the skid word when draining TWO, else the fetch bus.
  always_comb begin
    w_main_pc_d    = in_bus.pc;
    w_main_instr_d = in_bus.instr;
    if (w_main_from_skid) begin
      w_main_pc_d    = w_skid_pc;
      w_main_instr_d = w_skid_instr;
    end else begin
      w_main_pc_d    = in_bus.pc;
      w_main_instr_d = in_bus.instr;
    end
  end

  pipe_slot #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP(NOP)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_pc    (w_main_pc_d),
    .i_instr (w_main_instr_d),
    .o_pc    (w_main_pc),
    .o_instr (w_main_instr)
  );

  pipe_slot #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP(NOP)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (in_bus.pc),
    .i_instr (in_bus.instr),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  assign in_bus.ready  = w_in_ready;
  assign out_bus.valid = w_out_valid;
  assign out_bus.pc    = w_main_pc;
  assign out_bus.instr = w_main_instr;
  assign occupancy     = r_state;

endmodule : if_id_skid
